// File: rtl/fetch_pkg.sv
// Shared state encoding and instruction-format constants for the LEGv8 fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int OPC_HI      = 31;
  localparam int OPC_LO      = 21;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select: sequential step or word-scaled branch offset.
// Zero latency; no flow control, all arithmetic wraps modulo 2^ADDR_W.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] branch_imm,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              zero,
  output logic [ADDR_W-1:0] next_pc
);

  logic take;

  assign take    = uncond_branch | (branch & zero);
  assign next_pc = take ? pc + (branch_imm << 2) : pc + ADDR_W'(INSTR_BYTES);

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 fetch stage: ack->instr_valid 1 cycle, handshake->next imem_req 1 cycle; holds instr until instr_ready.
// Optional FETCH_PERF_CNT_EN adds retired_cnt/stall_cnt counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  startpc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [10:0]        opcode,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch,
  input  logic               uncond_branch,
  input  logic               zero,
  input  logic [ADDR_W-1:0]  branch_imm,
  output logic [ADDR_W-1:0]  currentpc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              load_instr;
  logic              handshake;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    load_instr = 1'b0;
    handshake  = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_instr = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          handshake = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc            (pc),
    .branch_imm    (branch_imm),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .next_pc       (pc_next)
  );

  // Masking rather than slicing keeps every startpc bit in use.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc    <= '0;
      instr <= '0;
    end else begin
      if (state == BOOT)  pc <= startpc & ~ADDR_W'(3);
      else if (handshake) pc <= pc_next;
      if (load_instr) instr <= imem_rdata;
    end
  end

  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc;
  assign currentpc   = pc;
  assign opcode      = instr[OPC_HI:OPC_LO];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (handshake) retired_cnt <= retired_cnt + 32'd1;
      if ((state == FETCH && !imem_ack) || (state == HOLD && !instr_ready))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected fetch addresses/instructions, a monitor checks them.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [63:0] startpc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0;
  logic        uncond_branch = 1'b0;
  logic        zero = 1'b0;
  logic [63:0] branch_imm = '0;
  logic [63:0] currentpc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] addr_q[$];
  logic [63:0] instr_q[$];
  logic        period_chk = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_vld = 1'b0;
  int          last_rise = -1;

  fetch_unit dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .startpc       (startpc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .branch_imm    (branch_imm),
    .currentpc     (currentpc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt   (retired_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[9:2], 24'h5A5A5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: each new fetch request and each new presented instruction is checked against the queues.
  initial begin : monitor
    logic [63:0] e;
    logic [31:0] w;
    forever begin
      @(negedge CLK);
      if (imem_req && !prev_req) begin
        if (addr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_fetch: got addr %h, expected no fetch", imem_addr);
        end else begin
          e = addr_q.pop_front();
          check("fetch_addr", imem_addr, e);
        end
      end
      if (instr_valid && !prev_vld) begin
        if (instr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_instr: got %h, expected no instruction", instr);
        end else begin
          e = instr_q.pop_front();
          w = mem_word(e);
          check("instr", 64'(instr), 64'(w));
          check("opcode", 64'(opcode), 64'(w[31:21]));
          check("currentpc", currentpc, e);
        end
        if (period_chk && last_rise >= 0) check("valid_period", 64'(cyc - last_rise), 64'd2);
        last_rise = period_chk ? cyc : -1;
      end
      prev_req = imem_req;
      prev_vld = instr_valid;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1);
  end

  task automatic serve_ack(input logic [63:0] exp, input int ack_dly);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("req_wait", 64'(imem_req), 64'd1);
    imem_ack = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge CLK);
      check("stall_fetch_req", 64'(imem_req), 64'd1);
      check("stall_fetch_addr", imem_addr, exp);
      check("stall_fetch_pc", currentpc, exp);
    end
    instr_q.push_back(exp);
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    @(negedge CLK);
    imem_ack = 1'b0;
  endtask

  task automatic serve_hold(input logic [63:0] exp, input int rdy_dly, input logic br,
                            input logic ub, input logic z, input logic [63:0] imm);
    instr_ready = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      // Don't-care inputs and a stray ack must not disturb the held instruction.
      uncond_branch = 1'b1;
      imem_ack      = 1'b1;
      imem_rdata    = 32'hDEADBEEF;
      @(negedge CLK);
      check("hold_valid", 64'(instr_valid), 64'd1);
      check("hold_instr", 64'(instr), 64'(mem_word(exp)));
      check("hold_pc", currentpc, exp);
      check("hold_addr", imem_addr, exp);
    end
    imem_ack      = 1'b0;
    instr_ready   = 1'b1;
    branch        = br;
    uncond_branch = ub;
    zero          = z;
    branch_imm    = imm;
    @(negedge CLK);
    instr_ready   = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    zero          = 1'b0;
    branch_imm    = '0;
  endtask

  task automatic serve(input logic [63:0] exp, input int ack_dly, input int rdy_dly,
                       input logic br, input logic ub, input logic z, input logic [63:0] imm);
    serve_ack(exp, ack_dly);
    serve_hold(exp, rdy_dly, br, ub, z, imm);
  endtask

  task automatic do_reset(input logic [63:0] spc);
    @(negedge CLK);
    #2;
    Reset       = 1'b1;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    startpc     = spc;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin : stimulus
    #1 Reset = 1'b1;
    #1;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_opcode", 64'(opcode), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_pc", currentpc, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_retired", 64'(retired_cnt), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
`endif

    // Sequential stream, zero-wait memory, always ready.
    period_chk = 1'b1;
    startpc    = 64'h100;
    addr_q.push_back(64'h100); addr_q.push_back(64'h104);
    addr_q.push_back(64'h108); addr_q.push_back(64'h10C);
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    check("first_req", 64'(imem_req), 64'd1);
    serve(64'h100, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0);
    serve(64'h104, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0);
    serve(64'h108, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0);
    period_chk = 1'b0;

    // Unconditional backward branch; startpc low bits ignored.
    addr_q.push_back(64'h200); addr_q.push_back(64'h1F8);
    do_reset(64'h202);
    serve(64'h200, 0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);

    // Conditional branch taken, then not taken.
    addr_q.push_back(64'h300); addr_q.push_back(64'h310);
    do_reset(64'h300);
    serve(64'h300, 0, 0, 1'b1, 1'b0, 1'b1, 64'd4);
    addr_q.push_back(64'h300); addr_q.push_back(64'h304);
    do_reset(64'h300);
    serve(64'h300, 0, 0, 1'b1, 1'b0, 1'b0, 64'd4);

    // Memory wait of 3 cycles then datapath stall of 2.
    addr_q.push_back(64'h400); addr_q.push_back(64'h404);
    do_reset(64'h400);
    serve(64'h400, 3, 2, 1'b0, 1'b0, 1'b0, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'd5);
    check("retired_cnt", 64'(retired_cnt), 64'd1);
`endif

    // PC wrap forward past 2^64, then negative offset wrapping below 0.
    addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC); addr_q.push_back(64'h0);
    addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    do_reset(64'hFFFF_FFFF_FFFF_FFFF);
    serve(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0);
    serve(64'h0, 0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Asynchronous reset while holding a live instruction.
    addr_q.push_back(64'h500);
    do_reset(64'h500);
    serve_ack(64'h500, 0);
    check("pre_rst_valid", 64'(instr_valid), 64'd1);
    #2 Reset = 1'b1;
    #1;
    check("async_valid", 64'(instr_valid), 64'd0);
    check("async_req", 64'(imem_req), 64'd0);
    check("async_pc", currentpc, 64'd0);
    check("async_instr", 64'(instr), 64'd0);
    addr_q.push_back(64'h500); addr_q.push_back(64'h504);
    @(negedge CLK);
    Reset = 1'b0;
    serve(64'h500, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0);

    repeat (2) @(negedge CLK);
    check("addr_q_drained", 64'(addr_q.size()), 64'd0);
    check("instr_q_drained", 64'(instr_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the LEGv8 single-cycle processor: holds the program counter, issues requests to instruction memory, and presents the fetched instruction and its 11-bit opcode field to the control decoder and datapath. It sits directly upstream of the control decoder. It consumes the decoder's `branch` and `uncond_branch` outputs, plus the ALU zero flag, to select the next PC when the datapath retires the current instruction.

## Interface
- `ADDR_W`, 64: PC and instruction-address width.
- `INSTR_W`, 32: instruction word width.
- `CLK`  input  1  single clock; all state updates on its rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `startpc`  input  ADDR_W  boot PC; bits [1:0] are ignored and treated as 0.
- `imem_req`  output  1  fetch request to instruction memory.
- `imem_addr`  output  ADDR_W  fetch address; equals current PC.
- `imem_ack`  input  1  instruction memory returns data this cycle.
- `imem_rdata`  input  INSTR_W  instruction word, valid when `imem_ack`=1.
- `instr`  output  INSTR_W  registered instruction.
- `opcode`  output  11  `instr[31:21]`, drives the control decoder.
- `instr_valid`  output  1  `instr`/`opcode` hold a live instruction.
- `instr_ready`  input  1  datapath retires the instruction this cycle.
- `branch`, `uncond_branch`  input  1 each  decoder outputs for the presented instruction.
- `zero`  input  1  ALU zero flag for the presented instruction.
- `branch_imm`  input  ADDR_W  sign-extended branch offset in words.
- `currentpc`  output  ADDR_W  PC of the presented/in-flight instruction.

## Operation
- FSM states: BOOT, FETCH, HOLD.
- BOOT is entered on Reset. In BOOT, `imem_req`=0. The first clock after Reset deasserts loads `pc` <= {startpc[ADDR_W-1:2],2'b00} and moves to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_ack`.
  - On `imem_ack`: `instr` <= `imem_rdata`, `instr_valid` <= 1, move to HOLD.
- HOLD:
  - `imem_req`=0. `instr`, `opcode` and `currentpc` are held stable until handshake.
  - Handshake is `instr_valid & instr_ready`.
  - On handshake, `take` = `uncond_branch | (branch & zero)`.
  - `pc` <= `take` ? `pc + (branch_imm << 2)` : `pc + 4`. `instr_valid` <= 0. Move to FETCH.
- `branch`, `uncond_branch`, `zero` and `branch_imm` are sampled only in the handshake cycle. They are don't-care otherwise.
- PC arithmetic is modulo 2^ADDR_W: `pc+4` from 2^64-4 wraps to 0, and a negative offset below 0 wraps.
- `imem_ack` outside FETCH is ignored and leaves no state change.
- `opcode` is always `instr[31:21]`, combinationally from the register.

## Timing
- Reset values:
  - state=BOOT, `pc`=0, `imem_req`=0, `imem_addr`=0.
  - `instr`=0, `opcode`=0, `instr_valid`=0, `currentpc`=0.
- Reset is asynchronous: asserting it in any state, mid-fetch or mid-hold, forces the reset values immediately. An outstanding memory request is abandoned.
- First `imem_req` is asserted 1 cycle after Reset deasserts (BOOT cycle).
- `imem_ack` to `instr_valid` latency: 1 cycle.
- Handshake to next `imem_req`: 1 cycle. With zero-wait memory and `instr_ready` tied high, throughput is 1 instruction per 2 cycles.
- `imem_ack` is allowed in the first FETCH cycle.
- `instr_ready` while `instr_valid`=0 has no effect.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `retired_cnt` (32) and `stall_cnt` (32), both reset to 0.
  - `retired_cnt` increments on each handshake.
  - `stall_cnt` increments each cycle in FETCH without `imem_ack`, and each cycle in HOLD without `instr_ready`.
  - Both counters wrap modulo 2^32.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg`:
  - State enum encoding (BOOT, FETCH, HOLD).
  - `INSTR_BYTES`=4.
  - Opcode field bounds `OPC_HI`=31, `OPC_LO`=21.
- Sub-module `next_pc_calc` (combinational): inputs `pc`, `branch_imm`, `branch`, `uncond_branch`, `zero`; output is the next PC. Instantiated once.

## Test plan
- Reset then startpc=0x100, zero-wait memory, `instr_ready`=1 -> `imem_addr` sequence 0x100, 0x104, 0x108; `instr_valid` pulses every 2nd cycle.
- HOLD with `uncond_branch`=1, `branch_imm`=-2, pc=0x200, handshake -> next `imem_addr`=0x1F8.
- `branch`=1 at pc=0x300, `branch_imm`=4: `zero`=1 -> 0x310; `zero`=0 -> 0x304.
- `imem_ack` delayed 3 cycles, then `instr_ready` withheld 2 cycles -> `imem_addr`, `instr` and `currentpc` stay stable; with the macro defined, `stall_cnt`=5.
- pc=0xFFFF_FFFF_FFFF_FFFC, no branch, handshake -> next `imem_addr`=0.
- Reset asserted in HOLD with `instr_valid`=1 -> `instr_valid`, `imem_req` and `currentpc` go to 0 without waiting for a clock edge; after release, fetch restarts from startpc.
